rv_mc_ctrl: RTL

Multi-cycle RV32I control unit: a registered FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) that sequences one instruction at a time over instruction- and data-memory handshakes with configurable wait states.
- Drives the same datapath selects as the single-cycle decoder (alu_op, sext_op, alua_sel, alub_sel, wb_sel, npc_op, br_un), encoded with the shared param header.
- Adds sub-word load/store sizing, illegal-instruction and bus-timeout traps, x0 write suppression and a retired-instruction counter.

---
 rtl/rv_mc_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle RV32I control unit.
//
// Sequences one instruction at a time through FETCH -> DECODE -> EXEC
// [-> MEM [-> WB]] and back to FETCH. Illegal encodings and memory
// timeouts park the FSM in TRAP until reset.
//
// Handshake: fetch_req / dram_req are held high for as long as the FSM
// waits in FETCH / MEM. The matching ready input (fetch_ready / dram_ready)
// completes the access in the cycle it is sampled high, and the request
// drops on the next cycle. Requests are never withdrawn early, except by
// reset or by a timeout trap.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   instruction         IR contents, stable from DECODE until next FETCH
//   br_eq, br_lt        branch comparator results
//   fetch_ready         instruction memory data valid
//   dram_ready          data memory access complete
//   fetch_req, ir_we    instruction fetch request / IR latch enable
//   pc_we, npc_op       PC update (retire pulse) / take branch-jump target
//   br_un               unsigned branch compare
//   rf_we, wb_sel       register write enable / writeback source
//   sext_op, alu_op     immediate format / ALU operation
//   alua_sel, alub_sel  ALU operand selects
//   dram_req, dram_we   data memory request / write
//   dram_size           00 byte, 01 half, 10 word
//   load_unsigned       zero-extend load data
//   illegal, bus_err    sticky trap cause flags
//   halted              FSM is in TRAP
//   instret             retired instruction count
//   fsm_state           current FSM state (debug visibility)
module rv_mc_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instruction,
   input  logic             br_eq,
   input  logic             br_lt,
   input  logic             fetch_ready,
   input  logic             dram_ready,
   output logic             fetch_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             npc_op,
   output logic             br_un,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       sext_op,
   output logic [3:0]       alu_op,
   output logic [1:0]       alua_sel,
   output logic [1:0]       alub_sel,
   output logic             dram_req,
   output logic             dram_we,
   output logic [1:0]       dram_size,
   output logic             load_unsigned,
   output logic             illegal,
   output logic             bus_err,
   output logic             halted,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       fsm_state
);

   // Opcodes
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   // Datapath select encodings shared with the single-cycle decoder
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [2:0] SEXT_I = 3'd0;
   localparam logic [2:0] SEXT_S = 3'd1;
   localparam logic [2:0] SEXT_B = 3'd2;
   localparam logic [2:0] SEXT_U = 3'd3;
   localparam logic [2:0] SEXT_J = 3'd4;

   localparam logic [1:0] A_PC   = 2'd0;
   localparam logic [1:0] A_RS1  = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;
   localparam logic [1:0] B_RS2  = 2'd0;
   localparam logic [1:0] B_IMM  = 2'd1;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_DRAM = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   // Timeout counter sizing; MEM_TIMEOUT of 0 turns the timeout off
   localparam int             TW     = $clog2(MEM_TIMEOUT + 2);
   localparam bit             TO_EN  = (MEM_TIMEOUT > 0);
   localparam logic [TW-1:0]  T_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      K_ALU, K_BRANCH, K_JUMP, K_LOAD, K_STORE, K_FENCE
   } kind_t;

   state_t        state, state_next;
   logic [TW-1:0] tcnt;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd;
   assign opcode = instruction[6:0];
   assign rd     = instruction[11:7];
   assign f3     = instruction[14:12];
   assign f7     = instruction[31:25];

   // rs1/rs2 fields only matter to the datapath
   logic unused_fields;
   assign unused_fields = ^instruction[24:15];

   // Decoded instruction attributes
   logic       d_legal, d_br_un, d_take;
   kind_t      d_kind;
   logic [3:0] d_alu_op;
   logic [2:0] d_sext;
   logic [1:0] d_alua, d_alub;

   logic rf_we_raw, set_illegal, set_bus_err, timeout_hit, waiting;

   function automatic logic [3:0] alu_fn(input logic [2:0] fn3, input logic alt);
      logic [3:0] r;
      case (fn3)
         3'b000:  r = alt ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = alt ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   always_comb begin
      d_legal  = 1'b0;
      d_kind   = K_ALU;
      d_alu_op = ALU_ADD;
      d_sext   = SEXT_I;
      d_alua   = A_RS1;
      d_alub   = B_IMM;
      d_br_un  = 1'b0;
      d_take   = 1'b0;
      case (opcode)
         OP_LUI: begin
            d_legal = 1'b1;
            d_sext  = SEXT_U;
            d_alua  = A_ZERO;
         end
         OP_AUIPC: begin
            d_legal = 1'b1;
            d_sext  = SEXT_U;
            d_alua  = A_PC;
         end
         OP_JAL: begin
            d_legal = 1'b1;
            d_kind  = K_JUMP;
            d_sext  = SEXT_J;
            d_alua  = A_PC;
         end
         OP_JALR: begin
            d_legal = (f3 == 3'b000);
            d_kind  = K_JUMP;
         end
         OP_BRANCH: begin
            d_legal = (f3[2:1] != 2'b01);
            d_kind  = K_BRANCH;
            d_sext  = SEXT_B;
            d_alua  = A_PC;
            d_br_un = f3[1];
            // f3[2] picks lt vs eq; f3[0] inverts (BNE/BGE/BGEU)
            d_take  = (f3[2] ? br_lt : br_eq) ^ f3[0];
         end
         OP_LOAD: begin
            d_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
            d_kind  = K_LOAD;
         end
         OP_STORE: begin
            d_legal = !f3[2] && (f3[1:0] != 2'b11);
            d_kind  = K_STORE;
            d_sext  = SEXT_S;
         end
         OP_IMM: begin
            if (f3 == 3'b001)
               d_legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101)
               d_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else
               d_legal = 1'b1;
            // bit 30 is immediate data except for shift-right
            d_alu_op = alu_fn(f3, f7[5] && (f3 == 3'b101));
         end
         OP_REG: begin
            d_legal  = (f7 == 7'b0000000) ||
                       ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            d_alub   = B_RS2;
            d_alu_op = alu_fn(f3, f7[5]);
         end
         OP_FENCE: begin
            d_legal = 1'b1;
            d_kind  = K_FENCE;
         end
         default: d_legal = 1'b0;
      endcase
   end

   assign waiting     = ((state == S_FETCH) && !fetch_ready) ||
                        ((state == S_MEM) && !dram_ready);
   assign timeout_hit = TO_EN && (tcnt == T_LAST);

   always_comb begin
      state_next    = state;
      fetch_req     = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      npc_op        = 1'b0;
      br_un         = 1'b0;
      rf_we_raw     = 1'b0;
      wb_sel        = WB_ALU;
      sext_op       = 3'd0;
      alu_op        = 4'd0;
      alua_sel      = 2'd0;
      alub_sel      = 2'd0;
      dram_req      = 1'b0;
      dram_we       = 1'b0;
      dram_size     = 2'b00;
      load_unsigned = 1'b0;
      set_illegal   = 1'b0;
      set_bus_err   = 1'b0;
      if (!rst) begin
         // Operand selects stay valid through MEM/WB so the address holds
         if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
            sext_op  = d_sext;
            alu_op   = d_alu_op;
            alua_sel = d_alua;
            alub_sel = d_alub;
            br_un    = d_br_un;
         end
         case (state)
            S_FETCH: begin
               fetch_req = 1'b1;
               ir_we     = fetch_ready;
               if (fetch_ready) begin
                  state_next = S_DECODE;
               end else if (timeout_hit) begin
                  state_next  = S_TRAP;
                  set_bus_err = 1'b1;
               end
            end
            S_DECODE: begin
               if (d_legal) begin
                  state_next = S_EXEC;
               end else begin
                  state_next  = S_TRAP;
                  set_illegal = 1'b1;
               end
            end
            S_EXEC: begin
               case (d_kind)
                  K_ALU: begin
                     rf_we_raw  = 1'b1;
                     pc_we      = 1'b1;
                     state_next = S_FETCH;
                  end
                  K_BRANCH: begin
                     npc_op     = d_take;
                     pc_we      = 1'b1;
                     state_next = S_FETCH;
                  end
                  K_JUMP: begin
                     npc_op     = 1'b1;
                     rf_we_raw  = 1'b1;
                     wb_sel     = WB_PC4;
                     pc_we      = 1'b1;
                     state_next = S_FETCH;
                  end
                  K_LOAD, K_STORE: state_next = S_MEM;
                  default: begin
                     pc_we      = 1'b1;
                     state_next = S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               dram_req      = 1'b1;
               dram_we       = (d_kind == K_STORE);
               dram_size     = f3[1:0];
               load_unsigned = f3[2];
               if (dram_ready) begin
                  if (d_kind == K_STORE) begin
                     pc_we      = 1'b1;
                     state_next = S_FETCH;
                  end else begin
                     state_next = S_WB;
                  end
               end else if (timeout_hit) begin
                  state_next  = S_TRAP;
                  set_bus_err = 1'b1;
               end
            end
            S_WB: begin
               rf_we_raw  = 1'b1;
               wb_sel     = WB_DRAM;
               pc_we      = 1'b1;
               state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
         endcase
      end
   end

   // x0 is hardwired to zero, so never write it
   assign rf_we     = rf_we_raw && (rd != 5'd0);
   assign halted    = (state == S_TRAP);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_FETCH;
         tcnt    <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
         instret <= '0;
      end else begin
         state <= state_next;
         if (set_illegal) illegal <= 1'b1;
         if (set_bus_err) bus_err <= 1'b1;
         if (pc_we) instret <= instret + CNT_W'(1);
         if (state_next != state)
            tcnt <= '0;
         else if (waiting && TO_EN)
            tcnt <= tcnt + TW'(1);
      end
   end

endmodule
